// File: rtl/io_led_pkg.sv
// Shared constants for the ext_io LED controller: register offsets and reset/active levels.
package io_led_pkg;

  localparam logic [1:0] REG_ONOFF  = 2'd0;
  localparam logic [1:0] REG_BLINK  = 2'd1;
  localparam logic [1:0] REG_DUTY   = 2'd2;
  localparam logic [1:0] REG_PERIOD = 2'd3;

  localparam logic [7:0] PERIOD_RST = 8'h07;

  // Pads are active-low: driving LED_ON lights the LED.
  localparam logic LED_ON = 1'b0;

endpackage

// File: rtl/io_led_timebase.sv
// Free-running PWM counter plus the blink prescaler / tick counter / phase toggle.
module io_led_timebase
  import io_led_pkg::*;
#(
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned PRESC_BITS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          period,
  input  logic                restart,
  output logic                blink_phase,
  output logic [PWM_BITS-1:0] pwm_cnt
);

  logic [PRESC_BITS-1:0] presc_reg;
  logic [7:0]            tick_cnt_reg;
  logic                  phase_reg;
  logic [PWM_BITS-1:0]   pwm_reg;
  logic                  tick;

  assign tick = (presc_reg == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg    <= '0;
      tick_cnt_reg <= '0;
      phase_reg    <= 1'b0;
      pwm_reg      <= '0;
    end else begin
      pwm_reg <= pwm_reg + 1'b1;
      // A restart overrides a coinciding tick: no toggle, counters cleared.
      if (restart) begin
        presc_reg    <= '0;
        tick_cnt_reg <= '0;
      end else begin
        presc_reg <= presc_reg + 1'b1;
        if (tick) begin
          if (tick_cnt_reg == period) begin
            tick_cnt_reg <= '0;
            phase_reg    <= ~phase_reg;
          end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
          end
        end
      end
    end
  end

  assign blink_phase = phase_reg;
  assign pwm_cnt     = pwm_reg;

endmodule

// File: rtl/io_led_ctrl.sv
// Register-mapped LED controller (on/off, blink, PWM duty, blink period) on the ext_io page.
// Define IO_LED_READBACK_EN to enable register readback on d_out/d_out_en.
module io_led_ctrl
  import io_led_pkg::*;
#(
  parameter int unsigned NUM_LEDS   = 5,
  parameter logic [15:0] BASE_ADDR  = 16'hDEFC,
  parameter int unsigned PWM_BITS   = 4,
  parameter int unsigned PRESC_BITS = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bus_access_strobe,
  input  logic [15:0]         a,
  input  logic                ext_io_en,
  input  logic                r_w_n,
  input  logic [7:0]          d_in,
  output logic [7:0]          d_out,
  output logic                d_out_en,
  output logic [NUM_LEDS-1:0] leds
);

  logic [NUM_LEDS-1:0] onoff_reg;
  logic [NUM_LEDS-1:0] blink_reg;
  logic [PWM_BITS-1:0] duty_reg;
  logic [7:0]          period_reg;
  logic [NUM_LEDS-1:0] leds_reg;
  logic [NUM_LEDS-1:0] leds_next;
  logic                sel;
  logic                wr;
  logic                restart;
  logic                blink_phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;
  logic                unused_d_in;

  assign sel     = bus_access_strobe & ext_io_en & (a[15:2] == BASE_ADDR[15:2]);
  assign wr      = sel & ~r_w_n;
  assign restart = wr & (a[1:0] == REG_PERIOD);

  // Data bits above the implemented LEDs/duty width are dropped on write.
  assign unused_d_in = ^d_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onoff_reg  <= '1;
      blink_reg  <= '0;
      duty_reg   <= '1;
      period_reg <= PERIOD_RST;
    end else if (wr) begin
      case (a[1:0])
        REG_ONOFF:  onoff_reg  <= d_in[NUM_LEDS-1:0];
        REG_BLINK:  blink_reg  <= d_in[NUM_LEDS-1:0];
        REG_DUTY:   duty_reg   <= d_in[PWM_BITS-1:0];
        REG_PERIOD: period_reg <= d_in;
        default: ;
      endcase
    end
  end

  io_led_timebase #(
    .PWM_BITS   (PWM_BITS),
    .PRESC_BITS (PRESC_BITS)
  ) u_timebase (
    .clk         (clk),
    .rst_n       (rst_n),
    .period      (period_reg),
    .restart     (restart),
    .blink_phase (blink_phase),
    .pwm_cnt     (pwm_cnt)
  );

  // Full duty is special-cased so the compare never leaves a dark cycle.
  assign pwm_on = (duty_reg == '1) | (pwm_cnt < duty_reg);

  generate
    for (genvar gi = 0; gi < int'(NUM_LEDS); gi++) begin : g_led
      assign leds_next[gi] = (~onoff_reg[gi] & (~blink_reg[gi] | blink_phase) & pwm_on)
                             ? LED_ON : ~LED_ON;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_reg <= '1;
    end else begin
      leds_reg <= leds_next;
    end
  end

  assign leds = leds_reg;

`ifdef IO_LED_READBACK_EN
  logic       rd;
  logic [7:0] rd_data;
  logic [7:0] d_out_reg;
  logic       d_out_en_reg;

  assign rd = sel & r_w_n;

  always_comb begin
    rd_data = '0;
    case (a[1:0])
      REG_ONOFF:  rd_data = 8'(onoff_reg);
      REG_BLINK:  rd_data = 8'(blink_reg);
      REG_DUTY:   rd_data = 8'(duty_reg);
      REG_PERIOD: rd_data = period_reg;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out_reg    <= '0;
      d_out_en_reg <= 1'b0;
    end else begin
      d_out_en_reg <= rd;
      if (rd) begin
        d_out_reg <= rd_data;
      end
    end
  end

  assign d_out    = d_out_reg;
  assign d_out_en = d_out_en_reg;
`else
  assign d_out    = '0;
  assign d_out_en = 1'b0;
`endif

endmodule
